// File: rtl/button_counter.sv
// Push-button up/down counter for the LED bank.
// Each button is synchronised, debounced and turned into press and
// auto-repeat events. The 8-bit count is shown directly on leds.

// One button: two-flop synchroniser, debounce filter and a
// press / hold / repeat FSM that emits a registered one-cycle event.
module button_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 250_000,
    parameter int unsigned HOLD_CYCLES     = 12_500_000,
    parameter int unsigned REPEAT_CYCLES   = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic event_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HELD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    localparam int unsigned        CNT_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]        HOLD_LOAD   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]        REPEAT_LOAD = 32'(REPEAT_CYCLES - 1);

    // sync_q[0] is the first stage, sync_q[1] the synchronised level.
    logic [1:0]       sync_q,  sync_d;
    logic             deb_q,   deb_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic             event_q, event_d;

    // State register: every flop of the channel, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            sync_q  <= '0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            timer_q <= '0;
            event_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            timer_q <= timer_d;
            event_q <= event_d;
        end
    end

    // Synchroniser shift and debounce: accept a new level only after it has
    // differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        sync_d = {sync_q[0], btn};
        deb_d  = deb_q;
        cnt_d  = '0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Next state: press arms the hold timer, expiry switches to repeat
    // reloads, a debounced release always returns to IDLE silently.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (deb_q) begin
                    state_d = S_HELD;
                    timer_d = HOLD_LOAD;
                end
            end
            S_HELD, S_REPEAT: begin
                if (!deb_q) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    state_d = S_REPEAT;
                    timer_d = REPEAT_LOAD;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output: an event on the press itself and on each timer expiry while held.
    always_comb begin
        event_d = 1'b0;
        if (deb_q) begin
            case (state_q)
                S_IDLE:           event_d = 1'b1;
                S_HELD, S_REPEAT: event_d = (timer_q == '0);
                default:          event_d = 1'b0;
            endcase
        end
    end

    assign event_o = event_q;

endmodule

module button_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 250_000,
    parameter int unsigned HOLD_CYCLES     = 12_500_000,
    parameter int unsigned REPEAT_CYCLES   = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] leds,
    output logic       up_pulse,
    output logic       down_pulse
);

    logic       up_event;
    logic       down_event;
    logic [7:0] count_q, count_d;

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn_up),
        .event_o (up_event)
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_down (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn_down),
        .event_o (down_event)
    );

    // Count register; it advances at the edge that ends the event pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Modulo-256 step; simultaneous up and down events cancel out.
    always_comb begin
        count_d = count_q;
        case ({up_event, down_event})
            2'b10:   count_d = count_q + 8'd1;
            2'b01:   count_d = count_q - 8'd1;
            default: count_d = count_q;
        endcase
    end

    assign leds       = count_q;
    assign up_pulse   = up_event;
    assign down_pulse = down_event;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter with short debounce/hold/repeat times.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_button_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] leds;
    logic       up_pulse;
    logic       down_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int n_up;
    int n_down;
    logic [7:0] exp_leds;
    logic       exp_pulse;

    button_counter #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .leds       (leds),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle and tally any pulses seen.
    task automatic tick_count();
        tick();
        n_up   += int'(up_pulse);
        n_down += int'(down_pulse);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One clean press of btn_up followed by enough idle time to return to IDLE.
    task automatic press_up();
        btn_up = 1'b1;
        for (int i = 0; i < 8; i++) tick_count();
        btn_up = 1'b0;
        for (int i = 0; i < 12; i++) tick_count();
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not reach summary within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held three cycles with both buttons toggling.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_up   = ~btn_up;
            btn_down = ~btn_down;
            tick();
            check("rst_leds", 32'(leds), 32'd0);
            check("rst_up", 32'(up_pulse), 32'd0);
            check("rst_down", 32'(down_pulse), 32'd0);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("post_rst_leds", 32'(leds), 32'd0);
        check("post_rst_up", 32'(up_pulse), 32'd0);
        check("post_rst_down", 32'(down_pulse), 32'd0);

        // Clean press: pulse after edge N+6, count 0 -> 1 at edge N+7.
        n_up = 0;
        n_down = 0;
        btn_up = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick_count();
            if (i == 6) begin
                check("press_no_early_pulse", 32'(up_pulse), 32'd0);
                check("press_leds_before", 32'(leds), 32'd0);
            end
            if (i == 7) begin
                check("press_pulse", 32'(up_pulse), 32'd1);
                check("press_leds_during", 32'(leds), 32'd0);
            end
            if (i == 8) begin
                check("press_pulse_end", 32'(up_pulse), 32'd0);
                check("press_leds_after", 32'(leds), 32'd1);
            end
        end
        btn_up = 1'b0;
        for (int i = 0; i < 30; i++) tick_count();
        check("press_up_count", 32'(n_up), 32'd1);
        check("press_down_count", 32'(n_down), 32'd0);
        check("press_leds_final", 32'(leds), 32'd1);

        // Bounce: 2-cycle toggles are filtered, the stable level gives one event.
        do_reset();
        n_up = 0;
        n_down = 0;
        for (int i = 0; i < 12; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            tick_count();
        end
        check("bounce_no_event", 32'(n_up), 32'd0);
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) tick_count();
        btn_up = 1'b0;
        for (int i = 0; i < 30; i++) tick_count();
        check("bounce_up_count", 32'(n_up), 32'd1);
        check("bounce_leds", 32'(leds), 32'd1);
        for (int r = 0; r < 3; r++) begin
            btn_down = 1'b1;
            for (int i = 0; i < 3; i++) tick_count();
            btn_down = 1'b0;
            for (int i = 0; i < 5; i++) tick_count();
        end
        check("glitch_down_count", 32'(n_down), 32'd0);
        check("glitch_leds", 32'(leds), 32'd1);

        // Hold btn_down from 0: press at tick 7, repeats at 27, 32, 37, 42, 47.
        do_reset();
        n_up = 0;
        n_down = 0;
        exp_leds = 8'd0;
        btn_down = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick_count();
            exp_pulse = (i == 7) || (i == 27) || (i == 32) || (i == 37) ||
                        (i == 42) || (i == 47);
            check($sformatf("hold_pulse_t%0d", i), 32'(down_pulse), 32'(exp_pulse));
            check($sformatf("hold_leds_t%0d", i), 32'(leds), 32'(exp_leds));
            if (exp_pulse) exp_leds = exp_leds - 8'd1;
            if (i == 43) btn_down = 1'b0;
        end
        check("hold_leds_final", 32'(leds), 32'd250);
        check("hold_down_count", 32'(n_down), 32'd6);
        check("hold_up_count", 32'(n_up), 32'd0);

        // Simultaneous press from leds = 7: both pulses, count unchanged.
        do_reset();
        for (int p = 0; p < 7; p++) press_up();
        check("simul_start_leds", 32'(leds), 32'd7);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                check("simul_up_pulse", 32'(up_pulse), 32'd1);
                check("simul_down_pulse", 32'(down_pulse), 32'd1);
            end
            if (i == 8) check("simul_leds", 32'(leds), 32'd7);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("simul_leds_final", 32'(leds), 32'd7);

        // Reset mid-repeat: leds 7 -> 12 while held, reset, then a fresh press.
        btn_up = 1'b1;
        for (int i = 1; i <= 43; i++) tick();
        check("midrep_leds", 32'(leds), 32'd12);
        rst_n = 1'b0;
        tick();
        check("midrep_rst_leds", 32'(leds), 32'd0);
        check("midrep_rst_up", 32'(up_pulse), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 6) check("repress_no_early", 32'(up_pulse), 32'd0);
            if (i == 7) begin
                check("repress_pulse", 32'(up_pulse), 32'd1);
                check("repress_leds_during", 32'(leds), 32'd0);
            end
            if (i == 8) check("repress_leds", 32'(leds), 32'd1);
        end
        btn_up = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_counter.md
Name: button_counter

Overview:
- Input-side counterpart to the board's free-running LED counter: the user drives the 8-bit LED value with two push-buttons instead of a timer.
- Synchronises and debounces btn_up and btn_down, and generates press and auto-repeat events.
- Maintains an 8-bit up/down count shown directly on leds.
- Sits between the raw board button pins and the LED bank, in the same clk domain as the rest of the LED logic.

Parameters:
- DEBOUNCE_CYCLES, 250_000, consecutive cycles a synchronised level must differ from the debounced level before it is accepted (10 ms at 25 MHz); must be >= 2.
- HOLD_CYCLES, 12_500_000, cycles from a press event to the first auto-repeat event (0.5 s); must be >= 2.
- REPEAT_CYCLES, 2_500_000, cycles between consecutive auto-repeat events (100 ms); must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- btn_up  input  1  raw asynchronous button; 1 = pressed.
- btn_down  input  1  raw asynchronous button; 1 = pressed.
- leds  output  8  current count.
- up_pulse  output  1  one-cycle strobe per accepted up event (press or repeat).
- down_pulse  output  1  one-cycle strobe per accepted down event.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Synchroniser flops, debounced levels, timers and count all cleared to 0.
  - Per-button FSM goes to IDLE.
  - leds = 0, up_pulse = 0, down_pulse = 0.
  - Reset has priority over all events.
- Synchroniser: two flops per button. A level first sampled at edge N is visible at the synchroniser output after edge N+1.
- Debounce, per button:
  - A counter increments each cycle the synchroniser output differs from the debounced level.
  - The counter clears to 0 on any cycle they match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips at that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored entirely.
- Per-button FSM (uses the debounced level, timer width 32 bits):
  - IDLE: on debounced rise, emit an event, load timer = HOLD_CYCLES-1, go to HELD.
  - HELD: decrement timer each cycle.
    - Timer reaching 0 with level still high: emit event, load timer = REPEAT_CYCLES-1, go to REPEAT.
    - Debounced fall: go to IDLE, no event.
  - REPEAT: decrement timer each cycle.
    - Timer reaching 0: emit event, reload REPEAT_CYCLES-1.
    - Debounced fall: go to IDLE, no event.
- Event timing:
  - Events are registered: up_pulse or down_pulse is high for exactly one cycle.
  - The count updates at the edge that ends the pulse cycle.
  - Press latency: a button stably pressed from first sampling edge N gives a count change at edge N+DEBOUNCE_CYCLES+3, exactly.
  - Repeat spacing: the first repeat pulse is HOLD_CYCLES cycles after the press pulse; subsequent repeat pulses are REPEAT_CYCLES apart.
- Count arithmetic: 8-bit modulo.
  - Up event: +1; 255 wraps to 0.
  - Down event: -1; 0 wraps to 255.
  - Up and down events in the same cycle: both pulses assert and the count is unchanged.
- Release never generates an event. Re-pressing after release restarts the full debounce and HOLD sequence.
- Reset mid-hold: the FSM returns to IDLE. A button still held after rst_n rises is treated as a new press, with the count changing at edge R+DEBOUNCE_CYCLES+3, where R is the first edge with rst_n high.
- leds is driven directly from the count register; no combinational path from any button input to any output.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5):
- Reset: hold rst_n low 3 cycles with both buttons toggling -> leds=0, up_pulse=0, down_pulse=0 throughout and 1 cycle after release.
- Clean press: btn_up high from edge N for 10 cycles, then low -> single up_pulse; leds 0->1 at edge N+7 exactly; no further pulses; no event on release.
- Bounce: btn_up toggles every 2 cycles for 12 cycles, then stays high 10 cycles -> exactly one up_pulse, leds=1; btn_down pulses of 3 cycles -> no event.
- Hold/wrap:
  - From leds=0, hold btn_down -> press pulse takes leds to 255.
  - Repeat pulses at +20, +25, +30, +35, +40 cycles after it -> leds=250 at release.
  - Release -> no further pulses.
- Simultaneous: btn_up and btn_down rise on the same edge from leds=7 -> up_pulse and down_pulse high in the same cycle; leds stays 7.
- Reset mid-repeat: with btn_up held in REPEAT and leds=12, assert rst_n low 2 cycles with the button still held -> leds=0 immediately; first up_pulse exactly 7 edges after rst_n rises gives leds=1.
